// File: rtl/driver_mon_pkg.sv
// rtl/driver_mon_pkg.sv - shared types, register map and helpers for driver_monitor_mc
package driver_mon_pkg;

    // Run-control state; the encoding is what CTRL reads back
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Register word indexes (byte address bits [9:2])
    localparam logic [7:0] REG_CTRL   = 8'h00;
    localparam logic [7:0] REG_STATUS = 8'h01;
    localparam logic [7:0] REG_CYCLE  = 8'h02;
    localparam logic [7:0] REG_OCC    = 8'h04;
    localparam logic [7:0] REG_EVT    = 8'h40;
    localparam logic [7:0] REG_SNAP   = 8'h80;

    // CTRL command bits
    localparam int CTRL_START = 0;
    localparam int CTRL_STOP  = 1;
    localparam int CTRL_CLEAR = 2;

    function automatic int num_bins(input int max_cycles, input int bin_range);
        return max_cycles / bin_range;
    endfunction

endpackage

// File: rtl/driver_mon_chan.sv
// rtl/driver_mon_chan.sv - per-channel occupancy tracker with event and snapshot bins
module driver_mon_chan #(
    parameter int CNT_W    = 16,
    parameter int NUM_BINS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             run,
    input  logic             wr,
    input  logic             rd,
    input  logic             snap,
    input  logic [3:0]       bin_idx,
    input  logic [3:0]       sel_bin,
    output logic [CNT_W-1:0] occupancy,
    output logic             overflow,
    output logic             underflow,
    output logic [CNT_W-1:0] event_val,
    output logic [CNT_W-1:0] snap_val
);
    localparam logic [CNT_W-1:0] ALL_ONES = '1;
    localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] occ_next;
    logic             ovf_hit;
    logic             unf_hit;
    logic [CNT_W-1:0] evt_q [NUM_BINS];
    logic [CNT_W-1:0] snp_q [NUM_BINS];

    // Next occupancy: saturate high, clamp low, simultaneous wr+rd cancels
    always_comb begin
        occ_next = occupancy;
        ovf_hit  = 1'b0;
        unf_hit  = 1'b0;
        if (wr && !rd) begin
            if (occupancy == ALL_ONES) ovf_hit = 1'b1;
            else                       occ_next = occupancy + ONE;
        end else if (rd && !wr) begin
            if (occupancy == '0) unf_hit = 1'b1;
            else                 occ_next = occupancy - ONE;
        end
    end

    // Occupancy and sticky flags advance only while the program runs
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            occupancy <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (run) begin
            occupancy <= occ_next;
            overflow  <= overflow | ovf_hit;
            underflow <= underflow | unf_hit;
        end
    end

    // Event counts and window-end snapshots for the current bin
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            for (int b = 0; b < NUM_BINS; b++) begin
                evt_q[b] <= '0;
                snp_q[b] <= '0;
            end
        end else if (run) begin
            for (int b = 0; b < NUM_BINS; b++) begin
                if (bin_idx == 4'(b)) begin
                    if (wr && evt_q[b] != ALL_ONES) evt_q[b] <= evt_q[b] + ONE;
                    if (snap) snp_q[b] <= occ_next;
                end
            end
        end
    end

    // Register-bus view of one bin; bins past NUM_BINS read as zero
    always_comb begin
        event_val = '0;
        snap_val  = '0;
        for (int b = 0; b < NUM_BINS; b++) begin
            if (sel_bin == 4'(b)) begin
                event_val = evt_q[b];
                snap_val  = snp_q[b];
            end
        end
    end

endmodule

// File: rtl/driver_monitor_mc.sv
// rtl/driver_monitor_mc.sv - multi-channel FIFO activity monitor with register readout
module driver_monitor_mc
    import driver_mon_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int CNT_W         = 16,
    parameter int BIN_RANGE     = 8,
    parameter int MAX_CYCLE_CNT = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       slave_addr,
    input  logic              slave_rd,
    input  logic              slave_wr,
    input  logic [31:0]       slave_data_in,
    output logic [31:0]       slave_data_out,
    output logic              slave_rd_val,
    input  logic [NUM_CH-1:0] ch_fifo_wr,
    input  logic [NUM_CH-1:0] ch_fifo_rd,
    output logic              run_program,
    output logic              active_program,
    output logic              end_program,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [NUM_CH-1:0] ch_overflow,
    output logic [NUM_CH-1:0] ch_underflow
);
    localparam int               NUM_BINS   = num_bins(MAX_CYCLE_CNT, BIN_RANGE);
    localparam int               BIN_SH     = $clog2(BIN_RANGE);
    localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(MAX_CYCLE_CNT - 1);
    localparam logic [CNT_W-1:0] WIN_MASK   = CNT_W'(BIN_RANGE - 1);
    localparam logic [CNT_W-1:0] ONE        = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    logic [7:0]       word;
    logic             ctrl_wr;
    logic             do_start;
    logic             do_stop;
    logic             do_clear;
    logic             in_run;
    logic             leave_run;
    logic             snap;
    logic [3:0]       bin_idx;
    logic [CNT_W-1:0] occ     [NUM_CH];
    logic [CNT_W-1:0] evt_val [NUM_CH];
    logic [CNT_W-1:0] snp_val [NUM_CH];
    logic [31:0]      status;
    logic [31:0]      rdata;
    logic             unused_bits;

    assign word        = slave_addr[9:2];
    assign unused_bits = ^{slave_addr[31:10], slave_addr[1:0], slave_data_in[31:3]};

    // Each command bit only acts in the one state where it is meaningful
    assign ctrl_wr   = slave_wr && (word == REG_CTRL);
    assign do_start  = ctrl_wr && slave_data_in[CTRL_START] && (state == ST_IDLE);
    assign do_stop   = ctrl_wr && slave_data_in[CTRL_STOP]  && (state == ST_RUN);
    assign do_clear  = ctrl_wr && slave_data_in[CTRL_CLEAR] && (state == ST_DONE);
    assign in_run    = (state == ST_RUN);
    assign leave_run = in_run && ((cycle_cnt == LAST_CYCLE) || do_stop);
    assign snap      = ((cycle_cnt & WIN_MASK) == WIN_MASK) || do_stop;
    assign bin_idx   = 4'(cycle_cnt >> BIN_SH);

    assign run_program    = in_run;
    assign active_program = (state == ST_RUN) || (state == ST_DONE);

    // Run-control FSM and cycle counter; cycle_cnt freezes on the final RUN cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cycle_cnt   <= '0;
            end_program <= 1'b0;
        end else begin
            end_program <= leave_run;
            case (state)
                ST_IDLE: begin
                    if (do_start) begin
                        state     <= ST_RUN;
                        cycle_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    if (leave_run) state     <= ST_DONE;
                    else           cycle_cnt <= cycle_cnt + ONE;
                end
                ST_DONE: begin
                    if (do_clear) begin
                        state     <= ST_IDLE;
                        cycle_cnt <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        driver_mon_chan #(
            .CNT_W    (CNT_W),
            .NUM_BINS (NUM_BINS)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .clear     (do_clear),
            .run       (in_run),
            .wr        (ch_fifo_wr[c]),
            .rd        (ch_fifo_rd[c]),
            .snap      (snap),
            .bin_idx   (bin_idx),
            .sel_bin   (word[3:0]),
            .occupancy (occ[c]),
            .overflow  (ch_overflow[c]),
            .underflow (ch_underflow[c]),
            .event_val (evt_val[c]),
            .snap_val  (snp_val[c])
        );
    end

    // STATUS packs overflow in the low half and underflow from bit 16
    always_comb begin
        status = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            status[c]      = ch_overflow[c];
            status[16 + c] = ch_underflow[c];
        end
    end

    // Read mux over the word address; unmapped words and absent channels read zero
    always_comb begin
        rdata = '0;
        if (word == REG_CTRL) begin
            rdata = {30'b0, state};
        end else if (word == REG_STATUS) begin
            rdata = status;
        end else if (word == REG_CYCLE) begin
            rdata = 32'(cycle_cnt);
        end else if (word[7:2] == REG_OCC[7:2]) begin
            for (int c = 0; c < NUM_CH; c++)
                if (word[1:0] == 2'(c)) rdata = 32'(occ[c]);
        end else if (word[7:6] == REG_EVT[7:6]) begin
            for (int c = 0; c < NUM_CH; c++)
                if (word[5:4] == 2'(c)) rdata = 32'(evt_val[c]);
        end else if (word[7:6] == REG_SNAP[7:6]) begin
            for (int c = 0; c < NUM_CH; c++)
                if (word[5:4] == 2'(c)) rdata = 32'(snp_val[c]);
        end
    end

    // One-cycle read pipeline; captures pre-write values on a same-cycle write
    always_ff @(posedge clk) begin
        if (reset) begin
            slave_data_out <= '0;
            slave_rd_val   <= 1'b0;
        end else begin
            slave_rd_val <= slave_rd;
            if (slave_rd) slave_data_out <= rdata;
        end
    end

endmodule

// File: tb/tb_driver_monitor_mc.sv
// tb/tb_driver_monitor_mc.sv - scoreboard bench for driver_monitor_mc
module tb_driver_monitor_mc;
    localparam int NCH  = 4;
    localparam int NBIN = 16;
    localparam int WIN  = 8;
    localparam int LAST = 127;
    localparam int MAXV = 65535;

    logic           clk = 1'b0;
    logic           reset;
    logic [31:0]    slave_addr, slave_data_in, data1, data2;
    logic           slave_rd, slave_wr, rd_val1, rd_val2;
    logic [NCH-1:0] ch_fifo_wr, ch_fifo_rd, ovf1, unf1;
    logic           run1, active1, end1;
    logic [15:0]    cyc1;
    logic           wr2, rd2, run2, active2, end2, ovf2, unf2;
    logic [7:0]     cyc2;

    always #5 clk = ~clk;

    driver_monitor_mc #(.NUM_CH(4), .CNT_W(16), .BIN_RANGE(8), .MAX_CYCLE_CNT(128)) dut (
        .clk(clk), .reset(reset), .slave_addr(slave_addr), .slave_rd(slave_rd),
        .slave_wr(slave_wr), .slave_data_in(slave_data_in), .slave_data_out(data1),
        .slave_rd_val(rd_val1), .ch_fifo_wr(ch_fifo_wr), .ch_fifo_rd(ch_fifo_rd),
        .run_program(run1), .active_program(active1), .end_program(end1),
        .cycle_cnt(cyc1), .ch_overflow(ovf1), .ch_underflow(unf1)
    );

    driver_monitor_mc #(.NUM_CH(1), .CNT_W(8), .BIN_RANGE(16), .MAX_CYCLE_CNT(256)) dut8 (
        .clk(clk), .reset(reset), .slave_addr(slave_addr), .slave_rd(slave_rd),
        .slave_wr(slave_wr), .slave_data_in(slave_data_in), .slave_data_out(data2),
        .slave_rd_val(rd_val2), .ch_fifo_wr(wr2), .ch_fifo_rd(rd2),
        .run_program(run2), .active_program(active2), .end_program(end2),
        .cycle_cnt(cyc2), .ch_overflow(ovf2), .ch_underflow(unf2)
    );

    // Reference model of the 4-channel instance (state: 0 idle, 1 run, 2 done)
    int m_state, m_cyc;
    int m_occ [NCH];
    int m_evt [NCH][NBIN];
    int m_snp [NCH][NBIN];
    bit m_ovf [NCH];
    bit m_unf [NCH];
    bit m_end, m_rdv, checking;
    int n_checks, n_errors;

    typedef struct { bit dut; logic [31:0] addr; logic [31:0] exp; } rd_exp_t;
    rd_exp_t sb[$];
    rd_exp_t mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void model_clear();
        m_cyc = 0;
        for (int c = 0; c < NCH; c++) begin
            m_occ[c] = 0; m_ovf[c] = 0; m_unf[c] = 0;
            for (int b = 0; b < NBIN; b++) begin m_evt[c][b] = 0; m_snp[c][b] = 0; end
        end
    endfunction

    // Applies what the coming clock edge does, given the inputs now on the pins
    function automatic void model_step();
        bit cmd, stop;
        int bin;
        cmd   = slave_wr && (slave_addr[9:2] == 8'h00);
        m_end = 0;
        m_rdv = slave_rd && !reset;
        if (reset) begin
            model_clear();
            m_state = 0;
            return;
        end
        if (m_state == 0) begin
            if (cmd && slave_data_in[0]) begin m_state = 1; m_cyc = 0; end
        end else if (m_state == 1) begin
            stop = cmd && slave_data_in[1];
            bin  = m_cyc / WIN;
            for (int c = 0; c < NCH; c++) begin
                if (ch_fifo_wr[c] && !ch_fifo_rd[c]) begin
                    if (m_occ[c] == MAXV) m_ovf[c] = 1; else m_occ[c]++;
                end else if (ch_fifo_rd[c] && !ch_fifo_wr[c]) begin
                    if (m_occ[c] == 0) m_unf[c] = 1; else m_occ[c]--;
                end
                if (ch_fifo_wr[c] && m_evt[c][bin] < MAXV) m_evt[c][bin]++;
                if ((m_cyc % WIN) == WIN - 1 || stop) m_snp[c][bin] = m_occ[c];
            end
            if (m_cyc == LAST || stop) begin m_state = 2; m_end = 1; end
            else m_cyc++;
        end else begin
            if (cmd && slave_data_in[2]) begin model_clear(); m_state = 0; end
        end
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        int w;
        logic [31:0] v;
        w = int'(addr[9:2]);
        v = '0;
        if (w == 0) v = m_state;
        else if (w == 1) begin
            for (int c = 0; c < NCH; c++) begin v[c] = m_ovf[c]; v[16 + c] = m_unf[c]; end
        end else if (w == 2) v = m_cyc;
        else if (w >= 4 && w < 8) v = m_occ[w - 4];
        else if (w >= 64 && w < 128) v = m_evt[(w - 64) / 16][(w - 64) % 16];
        else if (w >= 128 && w < 192) v = m_snp[(w - 128) / 16][(w - 128) % 16];
        return v;
    endfunction

    task automatic tick(input logic [NCH-1:0] w, input logic [NCH-1:0] r, input logic w2);
        ch_fifo_wr = w; ch_fifo_rd = r; wr2 = w2;
        model_step();
        @(negedge clk);
        slave_rd = 0; slave_wr = 0; ch_fifo_wr = '0; ch_fifo_rd = '0; wr2 = 0;
    endtask

    task automatic issue_read(input logic [31:0] addr, input bit dut_sel, input logic [31:0] exp8);
        rd_exp_t e;
        e.dut = dut_sel; e.addr = addr;
        e.exp = dut_sel ? exp8 : model_read(addr);
        sb.push_back(e);
        slave_rd = 1; slave_addr = addr;
    endtask

    task automatic issue_cmd(input logic [31:0] cmd);
        slave_wr = 1; slave_addr = 32'h0; slave_data_in = cmd;
    endtask

    task automatic rd_tick(input logic [31:0] addr);
        issue_read(addr, 0, 0); tick('0, '0, 0);
    endtask

    task automatic rd8_tick(input logic [31:0] addr, input logic [31:0] exp8);
        issue_read(addr, 1, exp8); tick('0, '0, 0);
    endtask

    task automatic cmd_tick(input logic [31:0] cmd);
        issue_cmd(cmd); tick('0, '0, 0);
    endtask

    task automatic rand_tick();
        tick(4'($urandom), 4'($urandom & $urandom), 1'b0);
    endtask

    task automatic rand_read();
        logic [31:0] r;
        logic [7:0]  w;
        r = $urandom;
        case ($urandom_range(0, 3))
            0:       w = 8'($urandom_range(0, 255));
            1:       w = 8'($urandom_range(0, 7));
            2:       w = 8'($urandom_range(64, 127));
            default: w = 8'($urandom_range(128, 191));
        endcase
        issue_read({r[31:10], w, r[1:0]}, 0, 0);
    endtask

    task automatic read_all();
        for (int a = 0; a < 8; a++) rd_tick(32'(4 * a));
        for (int c = 0; c < NCH; c++)
            for (int b = 0; b < NBIN; b++) begin
                rd_tick(32'h100 + 32'(64 * c + 4 * b));
                rd_tick(32'h200 + 32'(64 * c + 4 * b));
            end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 300 && m_state == 1; i++) tick('0, '0, 0);
    endtask

    // Monitor: per-cycle output checks plus scoreboard pops on read-valid
    always @(posedge clk) begin
        logic [31:0] fl;
        #2;
        if (checking) begin
            fl = '0;
            for (int c = 0; c < NCH; c++) begin fl[c] = m_ovf[c]; fl[16 + c] = m_unf[c]; end
            chk("end_program", 32'(end1), 32'(m_end));
            chk("run_active", {30'b0, run1, active1}, {30'b0, m_state == 1, m_state != 0});
            chk("cycle_cnt", 32'(cyc1), m_cyc);
            chk("flags", {12'b0, unf1, 12'b0, ovf1}, fl);
            chk("rd_val", {30'b0, rd_val1, rd_val2}, {30'b0, m_rdv, m_rdv});
            if (rd_val1) begin
                if (sb.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL unexpected_read: got data 0x%0h, expected no read", data1);
                end else begin
                    mon_e = sb.pop_front();
                    chk($sformatf("read dut%0d addr 0x%0h", mon_e.dut, mon_e.addr),
                        mon_e.dut ? data2 : data1, mon_e.exp);
                end
            end
        end
    end

    initial begin
        reset = 1; slave_addr = 0; slave_data_in = 0; slave_rd = 0; slave_wr = 0;
        ch_fifo_wr = '0; ch_fifo_rd = '0; wr2 = 0; rd2 = 0;
        n_checks = 0; n_errors = 0; checking = 1;
        tick('0, '0, 0); tick('0, '0, 0);
        reset = 0;

        // Reset state
        rd_tick(32'h000); rd_tick(32'h008); rd_tick(32'h010); rd_tick(32'h3FC);

        // Directed run: ch0 writes 20 cycles, ch1 underflow, ch2 wr+rd hold
        cmd_tick(32'h1);
        for (int i = 0; i < 20; i++) tick(4'b0001, (i == 0) ? 4'b0010 : 4'b0000, 0);
        for (int i = 0; i < 3; i++) tick(4'b0100, 4'b0000, 0);
        for (int i = 0; i < 4; i++) tick(4'b0100, 4'b0100, 0);
        rd_tick(32'h018); rd_tick(32'h014); rd_tick(32'h004);
        wait_done();
        rd_tick(32'h100); rd_tick(32'h104); rd_tick(32'h108);
        rd_tick(32'h200); rd_tick(32'h204); rd_tick(32'h010);
        rd_tick(32'h008); rd_tick(32'h000);
        cmd_tick(32'h4);
        rd_tick(32'h000); rd_tick(32'h104); rd_tick(32'h204);

        // Random run stopped at cycle 13 with a same-cycle CTRL read
        cmd_tick(32'h1);
        for (int i = 0; i < 13; i++) begin
            if (i == 5) issue_cmd(32'h4);
            rand_tick();
        end
        issue_cmd(32'h3); issue_read(32'h0, 0, 0); rand_tick();
        cmd_tick(32'h1);
        for (int i = 0; i < 5; i++) rand_tick();
        rd_tick(32'h000);
        read_all();
        cmd_tick(32'h7);
        read_all();

        // Random full run to natural end with interleaved random reads
        cmd_tick(32'h1);
        for (int i = 0; i < 200 && m_state == 1; i++) begin
            if ($urandom_range(0, 1) == 1) rand_read();
            rand_tick();
        end
        read_all();
        cmd_tick(32'h4);

        // Reset in the middle of a run
        cmd_tick(32'h1);
        for (int i = 0; i < 50; i++) rand_tick();
        reset = 1; tick('0, '0, 0); reset = 0;
        rd_tick(32'h000); rd_tick(32'h008); rd_tick(32'h010);

        // 8-bit instance: 300 writes saturate occupancy and set overflow
        reset = 1; tick('0, '0, 0); reset = 0;
        cmd_tick(32'h1);
        for (int i = 0; i < 300; i++) tick('0, '0, 1'b1);
        rd8_tick(32'h010, 32'd255);
        rd8_tick(32'h004, 32'h1);
        rd8_tick(32'h100, 32'd16);
        rd8_tick(32'h13C, 32'd16);
        rd8_tick(32'h21C, 32'd128);
        rd8_tick(32'h23C, 32'd255);
        rd8_tick(32'h008, 32'd255);
        rd8_tick(32'h000, 32'd2);
        chk("dut8 flags", {30'b0, ovf2, unf2}, 32'h2);
        chk("dut8 run_active_end", {29'b0, run2, active2, end2}, 32'h2);

        for (int i = 0; i < 3; i++) tick('0, '0, 0);
        chk("scoreboard drained", 32'(sb.size()), 32'h0);
        checking = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/driver_monitor_mc.md
Name: driver_monitor_mc

Overview:
Parametrised multi-channel successor to the single address/vector driver monitor. Tracks FIFO write/read activity on NUM_CH independent channels during a bounded program run. Bins per-channel write events and occupancy snapshots into fixed cycle windows. Exposes all results through the existing slave register bus.

Parameters:
NUM_CH, 4, number of monitored FIFO channels (1..4)
CNT_W, 16, width of every counter, occupancy and snapshot (8..32)
BIN_RANGE, 8, cycles per histogram window (power of 2)
MAX_CYCLE_CNT, 128, run length in cycles; NUM_BINS = MAX_CYCLE_CNT/BIN_RANGE (NUM_BINS must be in 1..16)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
slave_addr  in  32  byte address; bits [9:2] decoded, others ignored
slave_rd  in  1  read strobe
slave_wr  in  1  write strobe
slave_data_in  in  32  write data
slave_data_out  out  32  read data, valid one cycle after slave_rd
slave_rd_val  out  1  read-data-valid pulse
ch_fifo_wr  in  NUM_CH  per-channel FIFO write event
ch_fifo_rd  in  NUM_CH  per-channel FIFO read event
run_program  out  1  high in RUN
active_program  out  1  high in RUN or DONE
end_program  out  1  one-cycle pulse on RUN->DONE
cycle_cnt  out  CNT_W  cycles elapsed in current run
ch_overflow  out  NUM_CH  sticky: write seen at saturated occupancy
ch_underflow  out  NUM_CH  sticky: read seen at zero occupancy

Behaviour:
- Reset: state IDLE; all outputs, counters, bins, snapshots, occupancies and sticky flags 0.
- FSM IDLE->RUN on CTRL write with bit0 (start); RUN->DONE when cycle_cnt==MAX_CYCLE_CNT-1 or on CTRL write with bit1 (stop); DONE->IDLE on CTRL write with bit2 (clear), which zeroes all bins, snapshots, occupancies, flags and cycle_cnt.
- Ignored commands: start outside IDLE; stop outside RUN; clear in RUN. If multiple bits are set, only the bit valid for the current state acts.
- RUN: cycle_cnt increments each cycle starting from 0 in the first RUN cycle; bin index = cycle_cnt / BIN_RANGE (shift).
- Per channel each RUN cycle:
  - wr only: occupancy +1, saturating at all-ones; a write at all-ones sets overflow.
  - rd only: occupancy -1, clamped at 0; a read at 0 sets underflow.
  - wr and rd together: occupancy unchanged, no flag.
  - wr increments event_bin[ch][bin], saturating.
- On the last cycle of each window (cycle_cnt%BIN_RANGE==BIN_RANGE-1), or on a stop cycle, snap_bin[ch][bin] captures the post-update occupancy.
- Natural end and stop on the same cycle: single transition to DONE, single end_program pulse.
- Events outside RUN do not change any state.
- Register map (byte addresses); unmapped addresses read 0; writes to read-only registers are ignored:
  - 0x000 CTRL: write = command; read = {30'b0, state[1:0]}, with IDLE=0, RUN=1, DONE=2.
  - 0x004 STATUS = {underflow, overflow} at bits [NUM_CH+15:16] and [NUM_CH-1:0].
  - 0x008 cycle_cnt.
  - 0x010+4*ch live occupancy.
  - 0x100+0x40*ch+4*bin event_bin.
  - 0x200+0x40*ch+4*bin snap_bin.
  - All read values are zero-extended.
- Reads are 1-cycle latency. A read and write in the same cycle returns the pre-write value. Reset mid-run returns to IDLE with no end_program pulse.

Decomposition:
- Package driver_mon_pkg: state enum (IDLE/RUN/DONE), register offsets, CTRL bit positions, NUM_BINS derivation function.
- One sub-module, driver_mon_chan: per-channel occupancy, flags and bins, instantiated NUM_CH times by generate.
- Top-level holds the FSM, cycle counter and register read mux.

Test Plan:
- Reset, then read 0x000/0x008/0x010 -> all read 0 with slave_rd_val one cycle after each rd; run_program=0.
- Start; hold ch_fifo_wr[0]=1 for 20 cycles -> event_bin[0][0]=8, [0][1]=8, [0][2]=4, snap_bin[0][0]=8, [0][1]=16; end_program pulses at cycle 127; final occupancy 20.
- Channel 1: rd at occupancy 0 -> underflow[1]=1, occupancy stays 0. Simultaneous wr+rd on channel 2 at occupancy 3 -> stays 3.
- CNT_W=8: 300 writes on channel 0 -> occupancy 255, overflow[0]=1.
- Stop at cycle 13 -> DONE, end_program 1 pulse, snap_bin[ch][1] captured; a start in DONE is ignored; clear -> IDLE with all 0x100/0x200 reads 0.
- Assert reset at cycle 50 of a run -> state IDLE, cycle_cnt 0, no end_program pulse.
